// File: rtl/collision_manager_if.sv
// Bundle of pacman/ghost positions, the restart request and the round-state
// outputs exchanged between the collision manager and the rest of the game.
interface collision_manager_if #(
   parameter int NUM_GHOSTS = 2
);
   logic [9:0]              pac_x;
   logic [9:0]              pac_y;
   logic [10*NUM_GHOSTS-1:0] ghost_xs;
   logic [10*NUM_GHOSTS-1:0] ghost_ys;
   logic                    restart;
   logic                    soft_reset;
   logic                    hit_pulse;
   logic [1:0]              hit_ghost;
   logic [2:0]              lives;
   logic                    game_over;

   // Game side: supplies positions and restart, observes the round state.
   modport master (
      output pac_x, pac_y, ghost_xs, ghost_ys, restart,
      input  soft_reset, hit_pulse, hit_ghost, lives, game_over
   );

   // Collision manager side.
   modport slave (
      input  pac_x, pac_y, ghost_xs, ghost_ys, restart,
      output soft_reset, hit_pulse, hit_ghost, lives, game_over
   );
endinterface

// File: rtl/collision_manager.sv
// Pacman/ghost contact detection with debounce, life accounting and the
// PLAY/HIT/GRACE/GAME_OVER round machine that drives the movers' soft reset.
module collision_manager #(
   parameter int NUM_GHOSTS     = 2,
   parameter int HIT_DIST       = 12,
   parameter int CONFIRM_CYCLES = 2,
   parameter int RESET_HOLD     = 4,
   parameter int GRACE_CYCLES   = 25_000_000,
   parameter int INIT_LIVES     = 3
) (
   input  logic                clk,
   input  logic                rst,
   collision_manager_if.slave  bus
);

   localparam int CONF_W  = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
   localparam int HOLD_W  = (RESET_HOLD > 1)     ? $clog2(RESET_HOLD)     : 1;
   localparam int GRACE_W = (GRACE_CYCLES > 1)   ? $clog2(GRACE_CYCLES)   : 1;

   localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
   localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(GRACE_CYCLES - 1);
   localparam logic [2:0]         LIVES_INIT = 3'(INIT_LIVES);
   localparam logic [10:0]        DIST_LIM   = 11'(HIT_DIST);

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      HIT       = 2'd1,
      GRACE     = 2'd2,
      GAME_OVER = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 overlap_q, overlap_d;
   logic [1:0]           idx_q, idx_d;
   logic [CONF_W-1:0]    confirm_cnt_q, confirm_cnt_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [GRACE_W-1:0]   grace_cnt_q, grace_cnt_d;
   logic [2:0]           lives_q, lives_d;
   logic [1:0]           hit_ghost_q, hit_ghost_d;
   logic                 hit_pulse_q, hit_pulse_d;
   logic                 soft_reset_q, soft_reset_d;
   logic                 game_over_q, game_over_d;
   logic [NUM_GHOSTS-1:0] ghost_hit;

   // Positions are unsigned 0..1023, so an 11-bit signed difference never overflows.
   function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[10] ? $unsigned(-d) : $unsigned(d);
   endfunction

   always_comb begin
      ghost_hit = '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
         ghost_hit[i] = (abs_diff(bus.pac_x, bus.ghost_xs[10*i +: 10]) < DIST_LIM) &&
                        (abs_diff(bus.pac_y, bus.ghost_ys[10*i +: 10]) < DIST_LIM);
      end
   end

   // Scanning downward leaves the lowest overlapping index in idx_d.
   always_comb begin
      idx_d     = '0;
      overlap_d = |ghost_hit;
      for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
         if (ghost_hit[i]) idx_d = 2'(i);
      end
   end

   always_comb begin
      // NOTE: every _d starts from a default so no branch can leave it unassigned and infer a latch.
      state_d       = state_q;
      confirm_cnt_d = confirm_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      grace_cnt_d   = grace_cnt_q;
      lives_d       = lives_q;
      hit_ghost_d   = hit_ghost_q;
      hit_pulse_d   = 1'b0;

      unique case (state_q)
         PLAY: begin
            if (!overlap_q) begin
               confirm_cnt_d = '0;
            end else if (confirm_cnt_q == CONF_LAST) begin
               state_d       = HIT;
               hit_pulse_d   = 1'b1;
               hit_ghost_d   = idx_q;
               lives_d       = lives_q - 3'd1;
               hold_cnt_d    = '0;
               confirm_cnt_d = '0;
            end else begin
               confirm_cnt_d = confirm_cnt_q + CONF_W'(1);
            end
         end

         HIT: begin
            confirm_cnt_d = '0;
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               if (lives_q == 3'd0) begin
                  state_d = GAME_OVER;
               end else begin
                  state_d     = GRACE;
                  grace_cnt_d = '0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         GRACE: begin
            confirm_cnt_d = '0;
            if (grace_cnt_q == GRACE_LAST) begin
               state_d     = PLAY;
               grace_cnt_d = '0;
            end else begin
               grace_cnt_d = grace_cnt_q + GRACE_W'(1);
            end
         end

         GAME_OVER: begin
            confirm_cnt_d = '0;
            // A restart reuses HIT so the movers get their spawn-point reset.
            if (bus.restart) begin
               state_d    = HIT;
               lives_d    = LIVES_INIT;
               hold_cnt_d = '0;
            end
         end

         default: state_d = PLAY;
      endcase

      soft_reset_d = (state_d == HIT);
      game_over_d  = (state_d == GAME_OVER);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state takes non-blocking assignments only, so every flop sees pre-edge values.
      if (rst) begin
         state_q       <= PLAY;
         overlap_q     <= 1'b0;
         idx_q         <= '0;
         confirm_cnt_q <= '0;
         hold_cnt_q    <= '0;
         grace_cnt_q   <= '0;
         lives_q       <= LIVES_INIT;
         hit_ghost_q   <= '0;
         hit_pulse_q   <= 1'b0;
         soft_reset_q  <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         overlap_q     <= overlap_d;
         idx_q         <= idx_d;
         confirm_cnt_q <= confirm_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         grace_cnt_q   <= grace_cnt_d;
         lives_q       <= lives_d;
         hit_ghost_q   <= hit_ghost_d;
         hit_pulse_q   <= hit_pulse_d;
         soft_reset_q  <= soft_reset_d;
         game_over_q   <= game_over_d;
      end
   end

   assign bus.soft_reset = soft_reset_q;
   assign bus.hit_pulse  = hit_pulse_q;
   assign bus.hit_ghost  = hit_ghost_q;
   assign bus.lives      = lives_q;
   assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_collision_manager.sv
// Directed and randomized bench for collision_manager, checked every cycle
// against a countdown-based model of the round rules.
module tb_collision_manager;

   localparam int NG = 2;
   localparam int HD = 12;
   localparam int CC = 2;
   localparam int RH = 4;
   localparam int GC = 20;
   localparam int IL = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   collision_manager_if #(.NUM_GHOSTS(NG)) bus ();

   collision_manager #(
      .NUM_GHOSTS(NG), .HIT_DIST(HD), .CONFIRM_CYCLES(CC),
      .RESET_HOLD(RH), .GRACE_CYCLES(GC), .INIT_LIVES(IL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int pulses = 0;

   // Reference model: remaining HIT/GRACE cycles as countdowns, overlap streak as a count.
   int m_ov, m_idx, m_hold, m_grace, m_go, m_lives, m_streak, m_ghost, m_pulse;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit touch(input int px, input int py, input int gx, input int gy);
      int dx, dy;
      dx = (px > gx) ? px - gx : gx - px;
      dy = (py > gy) ? py - gy : gy - py;
      return (dx < HD) && (dy < HD);
   endfunction

   task automatic model_edge();
      int nov, nidx;
      nov  = 0;
      nidx = 0;
      for (int i = NG - 1; i >= 0; i--) begin
         if (touch(int'(bus.pac_x), int'(bus.pac_y),
                   int'(bus.ghost_xs[10*i +: 10]), int'(bus.ghost_ys[10*i +: 10]))) begin
            nov  = 1;
            nidx = i;
         end
      end
      if (rst) begin
         m_ov = 0; m_idx = 0; m_hold = 0; m_grace = 0; m_go = 0;
         m_lives = IL; m_streak = 0; m_ghost = 0; m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (m_hold > 0) begin
            m_streak = 0;
            if (m_hold == 1) begin
               m_hold = 0;
               if (m_lives == 0) m_go = 1;
               else m_grace = GC;
            end else begin
               m_hold--;
            end
         end else if (m_grace > 0) begin
            m_streak = 0;
            m_grace--;
         end else if (m_go != 0) begin
            if (bus.restart) begin
               m_go = 0; m_lives = IL; m_hold = RH;
            end
         end else if (m_ov != 0) begin
            if (m_streak + 1 == CC) begin
               m_pulse = 1; m_ghost = m_idx; m_lives--; m_hold = RH; m_streak = 0;
            end else begin
               m_streak++;
            end
         end else begin
            m_streak = 0;
         end
         m_ov  = nov;
         m_idx = nidx;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      if (bus.hit_pulse === 1'b1) pulses++;
      check("soft_reset", 32'(bus.soft_reset), 32'(m_hold > 0));
      check("hit_pulse",  32'(bus.hit_pulse),  32'(m_pulse));
      check("hit_ghost",  32'(bus.hit_ghost),  32'(m_ghost));
      check("lives",      32'(bus.lives),      32'(m_lives));
      check("game_over",  32'(bus.game_over),  32'(m_go));
   endtask

   task automatic set_ghost(input int i, input int x, input int y);
      bus.ghost_xs[10*i +: 10] = 10'(x);
      bus.ghost_ys[10*i +: 10] = 10'(y);
   endtask

   task automatic ghosts_far();
      set_ghost(0, 500, 400);
      set_ghost(1, 600, 40);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_pulse(input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.hit_pulse !== 1'b1 && n < limit);
   endtask

   task automatic count_soft_reset(output int n);
      n = 0;
      while (bus.soft_reset === 1'b1 && n < 20) begin
         n++;
         step();
      end
   endtask

   function automatic int clamp(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   initial begin
      int n, p0, run, px, py;

      rst = 1'b1;
      bus.restart = 1'b0;
      bus.pac_x = 10'd100;
      bus.pac_y = 10'd100;
      ghosts_far();
      apply_reset();
      check("rst_lives",      32'(bus.lives), 32'(IL));
      check("rst_soft_reset", 32'(bus.soft_reset), 0);
      check("rst_game_over",  32'(bus.game_over), 0);
      check("rst_hit_ghost",  32'(bus.hit_ghost), 0);

      // Single hit: pulse CONFIRM_CYCLES+1 edges after contact appears.
      set_ghost(0, 110, 105);
      wait_pulse(10, n);
      check("hit_latency", 32'(n), 32'(CC + 1));
      check("hit_ghost0",  32'(bus.hit_ghost), 0);
      check("lives_after_hit", 32'(bus.lives), 2);
      count_soft_reset(n);
      check("soft_reset_len", 32'(n), 32'(RH));
      ghosts_far();
      for (int i = 0; i < GC + 5; i++) step();

      // Restart outside GAME_OVER is ignored; exact HIT_DIST is no contact.
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      check("restart_ignored", 32'(bus.lives), 2);
      p0 = pulses;
      set_ghost(0, 112, 100);
      for (int i = 0; i < 100; i++) step();
      set_ghost(0, 111, 88);
      for (int i = 0; i < 20; i++) step();
      check("boundary_no_hit", 32'(pulses - p0), 0);
      set_ghost(0, 111, 89);
      wait_pulse(10, n);
      check("boundary_hit_latency", 32'(n), 32'(CC + 1));
      check("lives_boundary", 32'(bus.lives), 1);
      ghosts_far();
      for (int i = 0; i < GC + RH + 5; i++) step();

      // Glitch: overlap, gap, overlap never confirms.
      p0 = pulses;
      set_ghost(0, 105, 105); step();
      ghosts_far();           step();
      set_ghost(0, 105, 105); step();
      ghosts_far();
      for (int i = 0; i < 10; i++) step();
      check("glitch_no_pulse", 32'(pulses - p0), 0);
      check("glitch_lives", 32'(bus.lives), 1);

      // Grace: sustained overlap re-hits only after GRACE expires.
      apply_reset();
      set_ghost(0, 95, 92);
      wait_pulse(10, n);
      check("grace_first_latency", 32'(n), 32'(CC + 1));
      count_soft_reset(n);
      wait_pulse(GC + 40, n);
      check("grace_rehit_delay", 32'(n), 32'(GC + CC));
      check("grace_lives", 32'(bus.lives), 1);

      // Third hit ends the game.
      count_soft_reset(n);
      wait_pulse(GC + 40, n);
      check("third_hit_lives", 32'(bus.lives), 0);
      n = 0;
      while (bus.game_over !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("game_over_delay", 32'(n), 32'(RH));
      check("go_flag", 32'(bus.game_over), 1);
      check("go_soft_reset", 32'(bus.soft_reset), 0);
      p0 = pulses;
      for (int i = 0; i < 10; i++) step();
      check("go_no_pulse", 32'(pulses - p0), 0);
      check("go_lives_zero", 32'(bus.lives), 0);

      ghosts_far();
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      check("restart_lives", 32'(bus.lives), 3);
      check("restart_go", 32'(bus.game_over), 0);
      check("restart_pulse", 32'(bus.hit_pulse), 0);
      count_soft_reset(n);
      check("restart_soft_reset_len", 32'(n), 32'(RH));
      check("restart_no_pulse", 32'(pulses - p0), 0);

      // Simultaneous ghosts report the lowest index; reset mid-HIT.
      apply_reset();
      set_ghost(0, 105, 95);
      set_ghost(1, 95, 105);
      wait_pulse(10, n);
      check("multi_latency", 32'(n), 32'(CC + 1));
      check("multi_hit_ghost", 32'(bus.hit_ghost), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midhit_soft_reset", 32'(bus.soft_reset), 0);
      check("midhit_lives", 32'(bus.lives), 3);
      set_ghost(0, 500, 400);
      wait_pulse(10, n);
      check("ghost1_hit", 32'(bus.hit_ghost), 1);

      // Randomized play against the model.
      apply_reset();
      run = 0;
      px = 0;
      py = 0;
      for (int k = 0; k < 3000; k++) begin
         if (run == 0) begin
            run = int'($urandom_range(1, 6));
            px = int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 479));
            bus.pac_x = 10'(px);
            bus.pac_y = 10'(py);
            for (int g = 0; g < NG; g++) begin
               if ($urandom_range(0, 2) != 0)
                  set_ghost(g, clamp(px + int'($urandom_range(0, 28)) - 14, 639),
                               clamp(py + int'($urandom_range(0, 28)) - 14, 479));
               else
                  set_ghost(g, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
            end
         end
         run--;
         bus.restart = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 1'b0;
      bus.restart = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
